// File: rtl/iguana_reg_timeout.sv
// iguana_reg_timeout
// Register-interface guard in front of the HyperBus configuration port.
// Each upstream request is captured and forwarded downstream. If the
// downstream slave stays silent for TimeoutCycles WAIT cycles, the upstream
// transfer is completed with an error. The stalled downstream request is
// then drained: it is held until it completes, and its response is dropped.
// Optional feature macro: IGUANA_REG_TIMEOUT_ADDR_LOG_EN adds timeout_addr_o,
// which holds the address of the most recent timed-out request.
module iguana_reg_timeout #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   slv_valid_i,
  input  logic                   slv_write_i,
  input  logic [AddrWidth-1:0]   slv_addr_i,
  input  logic [DataWidth-1:0]   slv_wdata_i,
  input  logic [DataWidth/8-1:0] slv_wstrb_i,
  output logic                   slv_ready_o,
  output logic [DataWidth-1:0]   slv_rdata_o,
  output logic                   slv_error_o,
  output logic                   mst_valid_o,
  output logic                   mst_write_o,
  output logic [AddrWidth-1:0]   mst_addr_o,
  output logic [DataWidth-1:0]   mst_wdata_o,
  output logic [DataWidth/8-1:0] mst_wstrb_o,
  input  logic                   mst_ready_i,
  input  logic [DataWidth-1:0]   mst_rdata_i,
  input  logic                   mst_error_i,
  output logic                   timeout_o,
  output logic [15:0]            timeout_cnt_o,
`ifdef IGUANA_REG_TIMEOUT_ADDR_LOG_EN
  output logic [AddrWidth-1:0]   timeout_addr_o,
`endif
  input  logic                   clr_cnt_i
);

  // A timeout limit below 2 leaves no room for a downstream answer
  if (TimeoutCycles < 2) begin : g_param_check
    $error("iguana_reg_timeout: TimeoutCycles must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);

  state_e              state_r;
  state_e              state_next_s;
  logic [CntWidth-1:0] wait_cnt_r;
  logic [15:0]         tocnt_r;
  logic                accept_s;

  // A new request is taken only from IDLE, so requests arriving in DRAIN wait
  assign accept_s      = (state_r == ST_IDLE) && slv_valid_i;
  assign timeout_cnt_o = tocnt_r;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a real answer in the last WAIT cycle beats the timeout
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (slv_valid_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mst_ready_i) begin
          state_next_s = ST_IDLE;
        end else if (wait_cnt_r == LastCnt) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (mst_ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output logic: upstream completion and timeout pulse, same cycle as cause
  always_comb begin
    mst_valid_o = 1'b0;
    slv_ready_o = 1'b0;
    slv_rdata_o = '0;
    slv_error_o = 1'b0;
    timeout_o   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mst_valid_o = 1'b0;
      end
      ST_WAIT: begin
        mst_valid_o = 1'b1;
        if (mst_ready_i) begin
          slv_ready_o = 1'b1;
          slv_rdata_o = mst_rdata_i;
          slv_error_o = mst_error_i;
        end else if (wait_cnt_r == LastCnt) begin
          slv_ready_o = 1'b1;
          slv_error_o = 1'b1;
          timeout_o   = 1'b1;
        end else begin
          slv_ready_o = 1'b0;
        end
      end
      ST_DRAIN: begin
        mst_valid_o = 1'b1;
      end
      default: begin
        mst_valid_o = 1'b0;
      end
    endcase
  end

  // Request capture: fields stay frozen until the next accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mst_write_o <= 1'b0;
      mst_addr_o  <= '0;
      mst_wdata_o <= '0;
      mst_wstrb_o <= '0;
    end else if (accept_s) begin
      mst_write_o <= slv_write_i;
      mst_addr_o  <= slv_addr_i;
      mst_wdata_o <= slv_wdata_i;
      mst_wstrb_o <= slv_wstrb_i;
    end
  end

  // WAIT-cycle counter: restarted on capture, advanced while unanswered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_r <= '0;
    end else if (accept_s) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && !mst_ready_i && (wait_cnt_r != LastCnt)) begin
      wait_cnt_r <= wait_cnt_r + CntWidth'(1);
    end
  end

  // Saturating timeout statistic; a timeout coinciding with a clear counts as 1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tocnt_r <= 16'd0;
    end else if (timeout_o) begin
      if (clr_cnt_i) begin
        tocnt_r <= 16'd1;
      end else if (tocnt_r != 16'hFFFF) begin
        tocnt_r <= tocnt_r + 16'd1;
      end
    end else if (clr_cnt_i) begin
      tocnt_r <= 16'd0;
    end
  end

`ifdef IGUANA_REG_TIMEOUT_ADDR_LOG_EN
  // Address of the latest timed-out request; a timeout wins over a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_addr_o <= '0;
    end else if (timeout_o) begin
      timeout_addr_o <= mst_addr_o;
    end else if (clr_cnt_i) begin
      timeout_addr_o <= '0;
    end
  end
`endif

endmodule

// File: doc/iguana_reg_timeout.md
Name: iguana_reg_timeout

Overview:
- Register-interface guard between the SoC external register slave port and the HyperBus configuration register port. It sits directly upstream of the HyperBus config port.
- Captures each upstream request and forwards it downstream.
- If the downstream slave does not answer within a bounded number of cycles, it completes the upstream transfer with an error. It then drains the stalled downstream transfer, so an unresponsive PHY configuration path cannot hang the system bus.

Parameters:
- AddrWidth, 48, request address width.
- DataWidth, 32, data width; the strobe is DataWidth/8 bits.
- TimeoutCycles, 1024, WAIT-state cycles before an error response; must be >= 2 (elaboration-time assertion).
- CntWidth, $clog2(TimeoutCycles), timeout counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- slv_valid_i  in  1  upstream request valid
- slv_write_i  in  1  1 = write
- slv_addr_i  in  AddrWidth  upstream address
- slv_wdata_i  in  DataWidth  upstream write data
- slv_wstrb_i  in  DataWidth/8  upstream byte strobes
- slv_ready_o  out  1  upstream completion
- slv_rdata_o  out  DataWidth  upstream read data
- slv_error_o  out  1  upstream error
- mst_valid_o  out  1  downstream request valid
- mst_write_o  out  1  downstream write
- mst_addr_o  out  AddrWidth  downstream address
- mst_wdata_o  out  DataWidth  downstream write data
- mst_wstrb_o  out  DataWidth/8  downstream strobes
- mst_ready_i  in  1  downstream completion
- mst_rdata_i  in  DataWidth  downstream read data
- mst_error_i  in  1  downstream error
- timeout_o  out  1  one-cycle pulse per timeout
- timeout_cnt_o  out  16  saturating timeout count
- clr_cnt_i  in  1  synchronous clear of timeout_cnt_o

Behaviour:
- Protocol: the requester holds valid and its fields stable until ready. A transfer completes in the cycle where valid and ready are both 1.
- Reset (rst_i=1, asynchronous): state IDLE, all mst_* request registers 0, counter 0, timeout_cnt_o 0. All outputs are 0 while in reset.
- IDLE:
  - slv_ready_o=0 and mst_valid_o=0.
  - On slv_valid_i=1, register write/addr/wdata/wstrb, clear the counter, and go to WAIT. This adds one cycle of latency.
- WAIT:
  - mst_valid_o=1; mst_* come from the captured registers and are stable for the whole transfer.
  - If mst_ready_i=1: in the same cycle slv_ready_o=1, slv_rdata_o=mst_rdata_i, slv_error_o=mst_error_i; next state IDLE.
  - Else if counter==TimeoutCycles-1: in the same cycle slv_ready_o=1, slv_error_o=1, slv_rdata_o=0, timeout_o=1; timeout_cnt_o increments; next state DRAIN.
  - Else the counter increments.
  - If mst_ready_i=1 in the timeout cycle, normal completion wins and no timeout is flagged.
- DRAIN:
  - slv_ready_o=0 and mst_valid_o=1 with unchanged fields; the downstream request is never retracted.
  - On mst_ready_i=1, discard the response and go to IDLE.
  - An upstream request arriving during DRAIN is held off until IDLE.
- In IDLE and DRAIN, slv_rdata_o=0 and slv_error_o=0.
- The cycle after an upstream completion is always IDLE. A still-asserted slv_valid_i there is treated as a new request.
- timeout_cnt_o saturates at 16'hFFFF. If clr_cnt_i and a timeout occur in the same cycle, the result is 1.

Optional Feature:
- Macro: IGUANA_REG_TIMEOUT_ADDR_LOG_EN.
- When defined:
  - Adds output timeout_addr_o [AddrWidth].
  - It loads the captured address on each timeout, resets to 0, and clears with clr_cnt_i (the timeout wins if simultaneous).
- When undefined: the port and its register are absent; everything else is identical.

Test Plan (TimeoutCycles=8):
- Write, addr 0x10, data 0xA5A5A5A5, strb 0xF, slv_valid_i at cycle 0; mst_ready_i at cycle 4:
  - mst_valid_o in cycles 1-4 with those fields;
  - slv_ready_o=1 and slv_error_o=0 at cycle 4; IDLE at cycle 5.
- Read, addr 0x20, mst_ready_i never asserted:
  - slv_ready_o=1, slv_error_o=1, slv_rdata_o=0, timeout_o=1 at cycle 8; timeout_cnt_o=1;
  - mst_valid_o stays 1; mst_ready_i at cycle 20 gives IDLE at 21;
  - a pending upstream request is captured at 21 and forwarded at 22.
- Read, mst_ready_i=1 with rdata 0x12345678 exactly at cycle 8: slv_rdata_o=0x12345678, slv_error_o=0, timeout_o=0, counter unchanged.
- rst_i asserted in the 3rd WAIT cycle: mst_valid_o and slv_ready_o drop to 0 without a clock edge. After release, a new request is forwarded normally.
- Counter limits:
  - force 65540 timeouts: timeout_cnt_o holds 16'hFFFF;
  - clr_cnt_i alone gives 0; clr_cnt_i coincident with a timeout gives 1.
- With IGUANA_REG_TIMEOUT_ADDR_LOG_EN defined, timeout at addr 0x2C: timeout_addr_o=0x2C.
